parity_rx_checker: RTL and testbench

Serial even/odd parity frame checker, the receiving end of the XOR-based parity generator path in the small FPGA building-block library. It accepts a bit stream over a valid/ready handshake, deserialises `DATA_W` data bits (LSB first), and checks the trailing parity bit with a running XOR. It presents each completed word with a parity-error flag on a valid/ready output, and keeps a saturating error count.

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_acc.sv | 36 +++
 rtl/parity_rx_checker.sv | 143 ++++++++++++++
 tb/tb_parity_rx_checker.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker/generator path.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package parity_pkg;

    // Receiver frame states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Width of the saturating error counter.
    localparam int ERR_CNT_W = 8;

    // Bit-counter width: clog2 of the word width, never below 1 bit so a
    // single-bit frame still gets a legal vector.
    function automatic int cnt_w(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/parity_acc.sv
// 1-bit running XOR accumulator, shared by the parity generator and checker.
// Latency: 1 cycle from any control input to acc.
// Backpressure: none; the caller gates en/seed with its own handshake.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr         force the accumulator to 0
//   seed        load d as the new accumulator value (starts a new word)
//   en          XOR d into the accumulator
//   d           input bit
//   acc         current accumulator value
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic seed,
    input  logic en,
    input  logic d,
    output logic acc
);

    // seed outranks clr so a new frame can start on the same cycle the
    // previous word is retired.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (seed) begin
            acc <= d;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/parity_rx_checker.sv
// Serial even/odd parity frame checker: deserialises DATA_W bits LSB first, checks trailing parity.
// Latency: m_valid rises 1 cycle after the parity bit is accepted.
// Backpressure: s_ready drops while a word waits in HOLD; released the cycle after m_ready handshake.
//
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   s_bit/s_valid/s_sof     serial input bit, its valid, and first-data-bit marker
//   s_ready                 bit is accepted this cycle (decode of registered state only)
//   m_data/m_perr/m_valid   received word, parity-error flag, valid
//   m_ready                 consumer takes the word
//   err_cnt                 saturating count of parity errors plus aborted frames
module parity_rx_checker
    import parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_bit,
    input  logic                 s_valid,
    input  logic                 s_sof,
    output logic                 s_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic                 m_perr,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = cnt_w(DATA_W);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             acc;

    logic accept;
    logic start;      // accepted SOF bit: data bit 0 of a new frame
    logic abort;      // start that interrupts a frame in progress
    logic data_wr;    // accepted non-SOF data bit
    logic par_take;   // accepted non-SOF parity bit
    logic last_data;
    logic handshake;
    logic perr_new;
    logic err_inc;

    // Control decode and next state.
    always_comb begin
        s_ready   = 1'b1;
        accept    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        data_wr   = 1'b0;
        par_take  = 1'b0;
        handshake = 1'b0;
        state_nxt = state;

        s_ready   = (state != ST_HOLD);
        accept    = s_valid && s_ready;
        last_data = (cnt == CNT_W'(DATA_W - 1));

        case (state)
            ST_IDLE: begin
                start = accept && s_sof;
            end
            ST_DATA: begin
                start   = accept && s_sof;
                abort   = start;
                data_wr = accept && !s_sof;
            end
            ST_PARITY: begin
                start    = accept && s_sof;
                abort    = start;
                par_take = accept && !s_sof;
            end
            ST_HOLD: begin
                handshake = m_valid && m_ready;
            end
            default: ;
        endcase

        if (start) begin
            state_nxt = (DATA_W == 1) ? ST_PARITY : ST_DATA;
        end else if (data_wr && last_data) begin
            state_nxt = ST_PARITY;
        end else if (par_take) begin
            state_nxt = ST_HOLD;
        end else if (handshake) begin
            state_nxt = ST_IDLE;
        end
    end

    assign perr_new = acc ^ s_bit ^ ODD;
    // Abort and parity take are mutually exclusive (s_sof vs !s_sof), so
    // the counter moves by at most one per cycle.
    assign err_inc  = abort || (par_take && perr_new);

    parity_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (handshake),
        .seed  (start),
        .en    (data_wr),
        .d     (s_bit),
        .acc   (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            m_data  <= '0;
            m_perr  <= 1'b0;
            m_valid <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_nxt;

            // Unwritten m_data bits keep stale values; they are all
            // overwritten before m_valid can rise.
            if (start) begin
                m_data[0] <= s_bit;
                cnt       <= CNT_W'(1);
            end else if (data_wr) begin
                m_data[cnt] <= s_bit;
                cnt         <= cnt + CNT_W'(1);
            end

            if (par_take) begin
                m_perr  <= perr_new;
                m_valid <= 1'b1;
            end else if (handshake) begin
                m_valid <= 1'b0;
            end

            if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parity_rx_checker.sv
// Directed self-checking bench for parity_rx_checker (even and odd instances in lockstep).
// Latency: n/a.
// Backpressure: drives m_ready low to exercise HOLD.
module tb_parity_rx_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_bit, s_valid, s_sof, m_ready;
    logic       s_ready_e, s_ready_o;
    logic [7:0] m_data_e, m_data_o;
    logic       m_perr_e, m_perr_o;
    logic       m_valid_e, m_valid_o;
    logic [7:0] err_cnt_e, err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    parity_rx_checker #(.DATA_W(8), .ODD(1'b0)) dut_even (
        .clk(clk), .rst_n(rst_n), .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready_e), .m_data(m_data_e), .m_perr(m_perr_e), .m_valid(m_valid_e),
        .m_ready(m_ready), .err_cnt(err_cnt_e)
    );

    parity_rx_checker #(.DATA_W(8), .ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .s_bit(s_bit), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready_o), .m_data(m_data_o), .m_perr(m_perr_o), .m_valid(m_valid_o),
        .m_ready(m_ready), .err_cnt(err_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until accepted (bounded wait).
    task automatic send_bit(input logic b, input logic sof);
        int w;
        w       = 0;
        s_valid = 1'b1;
        s_bit   = b;
        s_sof   = sof;
        @(negedge clk);
        while (!s_ready_e && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready_e) chk("send_timeout", {31'd0, s_ready_e}, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    // Full frame: 8 data bits LSB first with SOF on bit 0, then parity.
    task automatic send_frame(input logic [7:0] d, input logic p);
        logic [7:0] dv;
        dv = d;
        send_bit(dv[0], 1'b1);
        for (int i = 1; i < 8; i++) send_bit(dv[i], 1'b0);
        chk("vld_before_parity", {31'd0, m_valid_e}, 32'd0);
        send_bit(p, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_vld"},   {31'd0, m_valid_e}, 32'd0);
        chk({tag, "_data"},  {24'd0, m_data_e},  32'd0);
        chk({tag, "_perr"},  {31'd0, m_perr_e},  32'd0);
        chk({tag, "_err"},   {24'd0, err_cnt_e}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, s_ready_e}, 32'd1);
    endtask

    initial begin
        logic [7:0] noise;
        rst_n   = 1'b0;
        s_bit   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
        step();
        do_reset();
        chk_reset_state("reset");

        // 0xA5 even parity correct.
        send_frame(8'hA5, 1'b0);
        chk("a5_vld",      {31'd0, m_valid_e}, 32'd1);
        chk("a5_data",     {24'd0, m_data_e},  32'hA5);
        chk("a5_perr",     {31'd0, m_perr_e},  32'd0);
        chk("a5_err",      {24'd0, err_cnt_e}, 32'd0);
        chk("a5_odd_perr", {31'd0, m_perr_o},  32'd1);
        step();
        chk("a5_vld_clr",  {31'd0, m_valid_e}, 32'd0);

        // 0xA5 with parity 1: even error, odd clean.
        send_frame(8'hA5, 1'b1);
        chk("a5p1_perr",     {31'd0, m_perr_e},  32'd1);
        chk("a5p1_err",      {24'd0, err_cnt_e}, 32'd1);
        chk("a5p1_odd_perr", {31'd0, m_perr_o},  32'd0);
        chk("a5p1_odd_err",  {24'd0, err_cnt_o}, 32'd1);
        step();

        // Backpressure.
        m_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rdy",  {31'd0, s_ready_e}, 32'd0);
            chk("bp_vld",  {31'd0, m_valid_e}, 32'd1);
            chk("bp_data", {24'd0, m_data_e},  32'hA5);
            chk("bp_perr", {31'd0, m_perr_e},  32'd0);
        end
        m_ready = 1'b1;
        step();
        chk("bp_vld_clr", {31'd0, m_valid_e}, 32'd0);
        chk("bp_rdy_set", {31'd0, s_ready_e}, 32'd1);
        send_frame(8'h3C, 1'b0);
        chk("3c_data", {24'd0, m_data_e},  32'h3C);
        chk("3c_perr", {31'd0, m_perr_e},  32'd0);
        chk("3c_err",  {24'd0, err_cnt_e}, 32'd1);
        step();

        // Resync: 4 data bits then a fresh SOF frame.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_frame(8'h0F, 1'b0);
        chk("resync_vld",  {31'd0, m_valid_e}, 32'd1);
        chk("resync_data", {24'd0, m_data_e},  32'h0F);
        chk("resync_perr", {31'd0, m_perr_e},  32'd0);
        chk("resync_err",  {24'd0, err_cnt_e}, 32'd2);
        step();
        chk("resync_single", {31'd0, m_valid_e}, 32'd0);

        // IDLE noise without SOF.
        noise = 8'b0000_0101;
        for (int i = 0; i < 3; i++) send_bit(noise[i], 1'b0);
        chk("noise_vld", {31'd0, m_valid_e}, 32'd0);
        chk("noise_err", {24'd0, err_cnt_e}, 32'd2);
        send_frame(8'h81, 1'b0);
        chk("81_data",    {24'd0, m_data_e},  32'h81);
        chk("81_perr",    {31'd0, m_perr_e},  32'd0);
        chk("81_odd_err", {24'd0, err_cnt_o}, 32'd6);
        step();

        // Reset mid-frame.
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        do_reset();
        chk_reset_state("rst_mid");

        // Reset while holding a word.
        m_ready = 1'b0;
        send_frame(8'h5A, 1'b0);
        chk("hold_vld", {31'd0, m_valid_e}, 32'd1);
        step();
        do_reset();
        chk_reset_state("rst_hold");
        m_ready = 1'b1;

        // Saturation: 300 bad-parity frames (even view).
        for (int f = 0; f < 300; f++) begin
            send_frame(8'h00, 1'b1);
            step();
        end
        chk("sat_err",     {24'd0, err_cnt_e}, 32'd255);
        chk("sat_odd_err", {24'd0, err_cnt_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
